// File: rtl/sprite_line_fetcher_pkg.sv
// Shared video definitions for the sprite line fetcher.
// Holds the sprite attribute word layout, sprite geometry constants,
// the transparent pixel code and the fetch FSM state encoding, plus
// small accessors that pull individual fields out of an attribute word.
package sprite_line_fetcher_pkg;

    // Attribute word: {en[21], idx[20:17], y[16:9], x[8:0]}
    localparam int ATTR_W       = 22;
    localparam int ATTR_EN_BIT  = 21;
    localparam int ATTR_IDX_LSB = 17;
    localparam int ATTR_IDX_W   = 4;
    localparam int ATTR_Y_LSB   = 9;
    localparam int ATTR_Y_W     = 8;
    localparam int ATTR_X_LSB   = 0;
    localparam int ATTR_X_W     = 9;

    // Sprite geometry
    localparam int SPR_W = 16;
    localparam int SPR_H = 16;
    localparam int COL_W = 4;
    localparam int ROW_W = 4;
    localparam int PIX_W = 4;

    localparam logic [PIX_W-1:0] PIX_TRANSPARENT = 4'd0;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ATTR,
        ST_CHECK,
        ST_FETCH,
        ST_DRAIN
    } state_e;

    function automatic logic attr_en(input logic [ATTR_W-1:0] a);
        return a[ATTR_EN_BIT];
    endfunction

    function automatic logic [ATTR_IDX_W-1:0] attr_idx(input logic [ATTR_W-1:0] a);
        return a[ATTR_IDX_LSB +: ATTR_IDX_W];
    endfunction

    function automatic logic [ATTR_Y_W-1:0] attr_y(input logic [ATTR_W-1:0] a);
        return a[ATTR_Y_LSB +: ATTR_Y_W];
    endfunction

    function automatic logic [ATTR_X_W-1:0] attr_x(input logic [ATTR_W-1:0] a);
        return a[ATTR_X_LSB +: ATTR_X_W];
    endfunction

endpackage

// File: rtl/sprite_line_fetcher_pixel_writer.sv
// sprite_pixel_writer: write stage of the sprite line fetcher.
// Delays the fetch strobe and column by one cycle so they line up with
// the pixel returned by sprite memory, forms the screen x position and
// masks transparent and off-line pixels.
// Ports:
//   clk, reset   - clock, asynchronous active-high reset
//   issue_i      - sprite memory read issued this cycle
//   squash_i     - drop the write that would follow this cycle's read
//   col_i        - column of the read issued this cycle
//   x_i          - sprite left edge (held stable through fetch/drain)
//   pix_i        - pixel returned by sprite memory (one cycle after issue)
//   lb_wen_o/lb_waddr_o/lb_wdata_o - line buffer write port
module sprite_pixel_writer
    import sprite_line_fetcher_pkg::*;
#(
    parameter int LINE_WIDTH = 320
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                issue_i,
    input  logic                squash_i,
    input  logic [COL_W-1:0]    col_i,
    input  logic [ATTR_X_W-1:0] x_i,
    input  logic [PIX_W-1:0]    pix_i,
    output logic                lb_wen_o,
    output logic [ATTR_X_W-1:0] lb_waddr_o,
    output logic [PIX_W-1:0]    lb_wdata_o
);

    logic             vld_q, vld_d;
    logic [COL_W-1:0] col_q, col_d;
    logic [9:0]       px;
    logic             opaque;
    logic             in_bounds;
    logic             wen;

    always_comb begin
        vld_d = issue_i & ~squash_i;
        col_d = col_i;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vld_q <= 1'b0;
            col_q <= '0;
        end else begin
            vld_q <= vld_d;
            col_q <= col_d;
        end
    end

    // Ten-bit sum so a sprite hanging off the right edge never wraps
    // back onto the left side of the line.
    always_comb begin
        px        = {1'b0, x_i} + {6'd0, col_q};
        in_bounds = (px < 10'(LINE_WIDTH));
        opaque    = (pix_i != PIX_TRANSPARENT);
        wen       = vld_q & opaque & in_bounds;
    end

    // Address/data are held at zero whenever no write is presented.
    assign lb_wen_o   = wen;
    assign lb_waddr_o = wen ? px[ATTR_X_W-1:0] : '0;
    assign lb_wdata_o = wen ? pix_i : '0;

endmodule

// File: rtl/sprite_line_fetcher.sv
// sprite_line_fetcher: per-scanline sprite fetch engine.
// On line_start it walks sprite slots from NUM_SPRITES-1 down to 0, reads
// each attribute, and for every sprite covering line_y fetches its 16-pixel
// row and writes the opaque, on-line pixels into the line buffer. Lower
// slots are written last and therefore win on overlap.
// Ports:
//   clk, reset            - clock, asynchronous active-high reset
//   line_start, line_y    - start/restart a pass for scanline line_y
//   busy, done            - pass in progress / one-cycle completion pulse
//   attr_ren/raddr/rdata  - sprite attribute table read port (1-cycle latency)
//   spr_ren/raddr/rdata   - sprite pixel memory read port (1-cycle latency)
//   lb_wen/waddr/wdata    - line buffer write port
module sprite_line_fetcher
    import sprite_line_fetcher_pkg::*;
#(
    parameter int NUM_SPRITES = 8,
    parameter int LINE_WIDTH  = 320
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           line_start,
    input  logic [7:0]                     line_y,
    output logic                           busy,
    output logic                           done,
    output logic                           attr_ren,
    output logic [$clog2(NUM_SPRITES)-1:0] attr_raddr,
    input  logic [21:0]                    attr_rdata,
    output logic                           spr_ren,
    output logic [11:0]                    spr_raddr,
    input  logic [3:0]                     spr_rdata,
    output logic                           lb_wen,
    output logic [8:0]                     lb_waddr,
    output logic [3:0]                     lb_wdata
);

    localparam int SLOT_W = $clog2(NUM_SPRITES);
    localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(NUM_SPRITES - 1);

    state_e                state_q, state_d;
    logic [SLOT_W-1:0]     slot_q, slot_d;
    logic [7:0]            ly_q, ly_d;
    logic [ATTR_IDX_W-1:0] idx_q, idx_d;
    logic [ROW_W-1:0]      row_q, row_d;
    logic [ATTR_X_W-1:0]   x_q, x_d;
    logic [COL_W-1:0]      col_q, col_d;
    logic                  done_q, done_d;

    logic [7:0]            attr_row;
    logic                  attr_hit;
    logic                  last_slot;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            slot_q  <= '0;
            ly_q    <= '0;
            idx_q   <= '0;
            row_q   <= '0;
            x_q     <= '0;
            col_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            slot_q  <= slot_d;
            ly_q    <= ly_d;
            idx_q   <= idx_d;
            row_q   <= row_d;
            x_q     <= x_d;
            col_q   <= col_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        slot_d  = slot_q;
        ly_d    = ly_q;
        idx_d   = idx_q;
        row_d   = row_q;
        x_d     = x_q;
        col_d   = col_q;
        done_d  = 1'b0;

        // Modulo-256 difference: a sprite starting near the bottom of the
        // frame wraps onto the top lines.
        attr_row  = ly_q - attr_y(attr_rdata);
        attr_hit  = attr_en(attr_rdata) && (attr_row < 8'(SPR_H));
        last_slot = (slot_q == '0);

        if (line_start) begin
            // Start or abort-and-restart; an aborted pass never signals done.
            state_d = ST_ATTR;
            ly_d    = line_y;
            slot_d  = LAST_SLOT;
        end else begin
            case (state_q)
                ST_IDLE: begin
                end
                ST_ATTR: begin
                    state_d = ST_CHECK;
                end
                ST_CHECK: begin
                    if (attr_hit) begin
                        idx_d   = attr_idx(attr_rdata);
                        row_d   = attr_row[ROW_W-1:0];
                        x_d     = attr_x(attr_rdata);
                        col_d   = '0;
                        state_d = ST_FETCH;
                    end else if (last_slot) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end else begin
                        slot_d  = slot_q - 1'b1;
                        state_d = ST_ATTR;
                    end
                end
                ST_FETCH: begin
                    col_d = col_q + 1'b1;
                    if (col_q == COL_W'(SPR_W - 1)) begin
                        state_d = ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (last_slot) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end else begin
                        slot_d  = slot_q - 1'b1;
                        state_d = ST_ATTR;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    assign busy       = (state_q != ST_IDLE);
    assign done       = done_q;
    assign attr_ren   = (state_q == ST_ATTR);
    assign attr_raddr = slot_q;
    assign spr_ren    = (state_q == ST_FETCH);
    assign spr_raddr  = {idx_q, row_q, col_q};

    sprite_pixel_writer #(
        .LINE_WIDTH (LINE_WIDTH)
    ) u_writer (
        .clk        (clk),
        .reset      (reset),
        .issue_i    (spr_ren),
        .squash_i   (line_start),
        .col_i      (col_q),
        .x_i        (x_q),
        .pix_i      (spr_rdata),
        .lb_wen_o   (lb_wen),
        .lb_waddr_o (lb_waddr),
        .lb_wdata_o (lb_wdata)
    );

endmodule

// File: tb/tb_sprite_line_fetcher.sv
module tb_sprite_line_fetcher;

    localparam int N  = 8;
    localparam int LW = 320;
    localparam int SW = $clog2(N);

    logic          clk = 1'b0;
    logic          reset;
    logic          line_start;
    logic [7:0]    line_y;
    logic          busy, done, attr_ren, spr_ren, lb_wen;
    logic [SW-1:0] attr_raddr;
    logic [21:0]   attr_rdata;
    logic [11:0]   spr_raddr;
    logic [3:0]    spr_rdata;
    logic [8:0]    lb_waddr;
    logic [3:0]    lb_wdata;

    logic [21:0]   attr_mem [N];
    logic [3:0]    spr_mem  [4096];
    logic [3:0]    lb_shadow [512];

    logic [11:0]   exp_ra [$];
    logic [12:0]   exp_wr [$];

    int n_vec = 0;
    int n_bad = 0;
    int done_cnt = 0;
    bit sb_on = 1'b0;

    sprite_line_fetcher #(
        .NUM_SPRITES (N),
        .LINE_WIDTH  (LW)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .line_start (line_start),
        .line_y     (line_y),
        .busy       (busy),
        .done       (done),
        .attr_ren   (attr_ren),
        .attr_raddr (attr_raddr),
        .attr_rdata (attr_rdata),
        .spr_ren    (spr_ren),
        .spr_raddr  (spr_raddr),
        .spr_rdata  (spr_rdata),
        .lb_wen     (lb_wen),
        .lb_waddr   (lb_waddr),
        .lb_wdata   (lb_wdata)
    );

    always #5 clk = ~clk;

    // Synchronous-read memories with one cycle of latency
    initial begin
        attr_rdata = '0;
        spr_rdata  = '0;
    end
    always @(posedge clk) begin
        if (attr_ren) attr_rdata <= attr_mem[attr_raddr];
        if (spr_ren)  spr_rdata  <= spr_mem[spr_raddr];
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Scoreboard monitor
    always @(negedge clk) begin
        logic [12:0] w;
        if (!reset && done) done_cnt++;
        if (sb_on && !reset) begin
            if (spr_ren) begin
                if (exp_ra.size() == 0) chk("spr_ren_extra", {31'd0, spr_ren}, 32'd0);
                else chk("spr_raddr", {20'd0, spr_raddr}, {20'd0, exp_ra.pop_front()});
            end
            if (lb_wen) begin
                lb_shadow[lb_waddr] = lb_wdata;
                if (exp_wr.size() == 0) chk("lb_wen_extra", {31'd0, lb_wen}, 32'd0);
                else begin
                    w = exp_wr.pop_front();
                    chk("lb_waddr", {23'd0, lb_waddr}, {23'd0, w[12:4]});
                    chk("lb_wdata", {28'd0, lb_wdata}, {28'd0, w[3:0]});
                end
            end
        end
    end

    // Reference model: walk slots high to low, push expected reads/writes,
    // return cycles from line_start to the done pulse.
    function automatic int model_pass(input logic [7:0] ly);
        int cyc, row, addr, px;
        logic [21:0] a;
        cyc = 0;
        for (int s = N - 1; s >= 0; s--) begin
            a   = attr_mem[s];
            row = (int'(ly) - int'(a[16:9]) + 256) % 256;
            if (a[21] && row < 16) begin
                for (int c = 0; c < 16; c++) begin
                    addr = int'(a[20:17]) * 256 + row * 16 + c;
                    px   = int'(a[8:0]) + c;
                    exp_ra.push_back(12'(addr));
                    if (spr_mem[addr] != 4'd0 && px < LW)
                        exp_wr.push_back({9'(px), spr_mem[addr]});
                end
                cyc += 19;
            end else begin
                cyc += 2;
            end
        end
        return cyc + 1;
    endfunction

    task automatic clear_attr();
        for (int s = 0; s < N; s++) attr_mem[s] = '0;
    endtask

    task automatic fill_sprite(input int idx, input logic [3:0] v);
        for (int i = 0; i < 256; i++) spr_mem[idx * 256 + i] = v;
    endtask

    task automatic clear_shadow();
        for (int i = 0; i < 512; i++) lb_shadow[i] = '0;
    endtask

    task automatic wait_done(input string nm, input int exp_lat);
        int n;
        n = 1;
        while (!done && n < 2000) begin
            @(posedge clk); #1;
            n++;
        end
        chk({nm, "_done_latency"}, n, exp_lat);
        @(posedge clk); #1;
        chk({nm, "_done_single"}, {31'd0, done}, 32'd0);
        chk({nm, "_idle_busy"}, {31'd0, busy}, 32'd0);
        chk({nm, "_reads_left"}, exp_ra.size(), 0);
        chk({nm, "_writes_left"}, exp_wr.size(), 0);
        exp_ra.delete();
        exp_wr.delete();
    endtask

    task automatic run_pass(input string nm, input logic [7:0] ly);
        int lat;
        lat = model_pass(ly);
        sb_on = 1'b1;
        @(posedge clk); #1;
        line_start = 1'b1;
        line_y     = ly;
        @(posedge clk); #1;
        line_start = 1'b0;
        chk({nm, "_attr_ren"}, {31'd0, attr_ren}, 32'd1);
        chk({nm, "_attr_raddr"}, {29'd0, attr_raddr}, N - 1);
        wait_done(nm, lat);
    endtask

    task automatic chk_outputs_zero(input string nm);
        chk({nm, "_busy"}, {31'd0, busy}, 32'd0);
        chk({nm, "_done"}, {31'd0, done}, 32'd0);
        chk({nm, "_attr_ren"}, {31'd0, attr_ren}, 32'd0);
        chk({nm, "_spr_ren"}, {31'd0, spr_ren}, 32'd0);
        chk({nm, "_lb_wen"}, {31'd0, lb_wen}, 32'd0);
        chk({nm, "_attr_raddr"}, {29'd0, attr_raddr}, 32'd0);
        chk({nm, "_spr_raddr"}, {20'd0, spr_raddr}, 32'd0);
        chk({nm, "_lb_waddr"}, {23'd0, lb_waddr}, 32'd0);
        chk({nm, "_lb_wdata"}, {28'd0, lb_wdata}, 32'd0);
    endtask

    // Starts a pass with the scoreboard off and stops once spr_ren has been
    // seen for `extra` further cycles.
    task automatic start_and_reach_fetch(input logic [7:0] ly, input int extra);
        int n;
        sb_on = 1'b0;
        @(posedge clk); #1;
        line_start = 1'b1;
        line_y     = ly;
        @(posedge clk); #1;
        line_start = 1'b0;
        n = 0;
        while (!spr_ren && n < 500) begin
            @(posedge clk); #1;
            n++;
        end
        chk("reach_fetch_spr_ren", {31'd0, spr_ren}, 32'd1);
        repeat (extra) begin
            @(posedge clk); #1;
        end
    endtask

    initial begin
        int lat;
        logic [7:0] ly;
        logic [7:0] y;
        int v;

        reset      = 1'b1;
        line_start = 1'b0;
        line_y     = '0;
        clear_attr();
        for (int i = 0; i < 4096; i++) spr_mem[i] = '0;
        clear_shadow();

        repeat (3) @(posedge clk);
        #1;
        chk_outputs_zero("in_reset");
        reset = 1'b0;
        @(posedge clk); #1;
        chk_outputs_zero("after_reset");

        // Single sprite
        fill_sprite(3, 4'd5);
        attr_mem[0] = {1'b1, 4'd3, 8'd10, 9'd100};
        clear_shadow();
        run_pass("single", 8'd12);
        chk("single_lb100", {28'd0, lb_shadow[100]}, 32'd5);
        chk("single_lb116", {28'd0, lb_shadow[116]}, 32'd0);

        // Transparency and right-edge clip
        for (int c = 0; c < 16; c++) spr_mem[3 * 256 + 2 * 16 + c] = (c % 2 == 1) ? 4'd7 : 4'd0;
        attr_mem[0] = {1'b1, 4'd3, 8'd10, 9'd310};
        clear_shadow();
        run_pass("clip", 8'd12);
        chk("clip_lb319", {28'd0, lb_shadow[319]}, 32'd7);
        chk("clip_lb310", {28'd0, lb_shadow[310]}, 32'd0);

        // Vertical wrap hit, then row-16 miss
        fill_sprite(3, 4'd5);
        attr_mem[0] = {1'b1, 4'd3, 8'd250, 9'd40};
        run_pass("wrap_hit", 8'd4);
        attr_mem[0] = {1'b1, 4'd3, 8'd4, 9'd40};
        run_pass("row16_miss", 8'd20);

        // Overlap: slot 0 drawn last and wins
        clear_attr();
        fill_sprite(1, 4'd2);
        fill_sprite(2, 4'd9);
        attr_mem[0] = {1'b1, 4'd1, 8'd30, 9'd50};
        attr_mem[1] = {1'b1, 4'd2, 8'd30, 9'd50};
        clear_shadow();
        run_pass("overlap", 8'd35);
        for (int i = 50; i < 66; i++) chk("overlap_final", {28'd0, lb_shadow[i]}, 32'd2);

        // Restart while fetching
        clear_attr();
        fill_sprite(4, 4'd6);
        attr_mem[7] = {1'b1, 4'd4, 8'd60, 9'd0};
        attr_mem[0] = {1'b1, 4'd1, 8'd60, 9'd200};
        done_cnt = 0;
        start_and_reach_fetch(8'd64, 5);
        exp_ra.delete();
        exp_wr.delete();
        lat = model_pass(8'd62);
        line_start = 1'b1;
        line_y     = 8'd62;
        @(posedge clk); #1;
        line_start = 1'b0;
        chk("restart_squash_lb_wen", {31'd0, lb_wen}, 32'd0);
        chk("restart_attr_ren", {31'd0, attr_ren}, 32'd1);
        chk("restart_attr_raddr", {29'd0, attr_raddr}, N - 1);
        sb_on = 1'b1;
        wait_done("restart", lat);
        repeat (20) @(posedge clk);
        #1;
        chk("restart_done_count", done_cnt, 1);

        // Asynchronous reset mid-fetch
        start_and_reach_fetch(8'd64, 3);
        #2;
        reset = 1'b1;
        #1;
        chk_outputs_zero("async_reset");
        @(posedge clk); #3;
        reset = 1'b0;
        exp_ra.delete();
        exp_wr.delete();
        @(posedge clk); #1;
        chk_outputs_zero("post_async_idle");
        run_pass("post_reset", 8'd64);

        // Randomized passes
        for (int i = 0; i < 4096; i++) begin
            v = $urandom_range(0, 22);
            spr_mem[i] = (v > 15) ? 4'd0 : 4'(v);
        end
        for (int p = 0; p < 12; p++) begin
            ly = 8'($urandom_range(0, 255));
            for (int s = 0; s < N; s++) begin
                y = ly - 8'($urandom_range(0, 31));
                attr_mem[s] = {($urandom_range(0, 3) != 0), 4'($urandom_range(0, 15)), y,
                               9'($urandom_range(0, 511))};
            end
            run_pass("random", ly);
            repeat ($urandom_range(0, 3)) @(posedge clk);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
